// File: rtl/sim_exit_monitor.sv
// Store-bus snooper for simulation bring-up: console byte FIFO,
// tohost exit port and a run-cycle watchdog.
module sim_exit_monitor #(
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_7F00,
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000_7F04,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned TIMEOUT      = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready,
  output logic        overflow,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic [31:0] cycles
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   TO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [31:0]   r_cycles;
  logic          r_done;
  logic          r_pass;
  logic [30:0]   r_fail_code;
  logic          r_overflow;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic w_run;
  logic w_cons_st;
  logic w_exit_st;
  logic w_timeout;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_run     = (r_state == S_RUN);
  assign w_cons_st = w_run && mem_write
                   && (addr == CONSOLE_ADDR);
  assign w_exit_st = w_run && mem_write
                   && (addr == TOHOST_ADDR)
                   && wdata[0];
  // A program exit in the last budgeted cycle beats the watchdog.
  assign w_timeout = w_run && !w_exit_st
                   && (r_cycles == TO_LAST);

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);
  assign w_pop   = !w_empty && cons_ready;
  assign w_push  = w_cons_st && (!w_full || w_pop);
  assign w_drop  = w_cons_st && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_cycles    <= '0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_code <= '0;
    end else begin
      unique case (r_state)
        S_RUN: begin
          r_cycles <= r_cycles + 32'd1;
          if (w_exit_st) begin
            r_fail_code <= wdata[31:1];
            r_pass      <= (wdata[31:1] == 31'd0);
            r_state     <= S_DRAIN;
          end else if (w_timeout) begin
            r_fail_code <= '1;
            r_pass      <= 1'b0;
            r_state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  // Gate the data so an empty FIFO never shows stale storage.
  assign cons_valid = !w_empty;
  assign cons_data  = w_empty ? 8'h00
                              : r_mem[r_rd_ptr];
  assign overflow   = r_overflow;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_code  = r_fail_code;
  assign cycles     = r_cycles;

endmodule
